// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: assembles streamed config words into LUT frames
// and commits them to each LUT in turn via a one-hot enable.
module lut_cfg_loader #(
  parameter int NUM_LUTS     = 8,
  parameter int INPUTS       = 4,
  parameter int MEM_SIZE     = 2**INPUTS,
  parameter int CONFIG_WIDTH = 4,
  parameter int IDX_W        = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic                    cclk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [CONFIG_WIDTH-1:0] s_data,
  output logic [MEM_SIZE-1:0]     config_out,
  output logic [NUM_LUTS-1:0]     cen,
  output logic [IDX_W-1:0]        lut_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int W     = MEM_SIZE / CONFIG_WIDTH;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LUTS - 1);

  if (NUM_LUTS < 1) begin : g_bad_luts
    $error("NUM_LUTS must be at least 1");
  end
  if ((MEM_SIZE % CONFIG_WIDTH) != 0) begin : g_bad_width
    $error("MEM_SIZE must be a multiple of CONFIG_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [MEM_SIZE-1:0] frame_q, frame_d;
  logic [MEM_SIZE-1:0] cfg_q, cfg_d;
  logic [NUM_LUTS-1:0] cen_q, cen_d;
  logic                done_q, done_d;

  logic hs;
  logic last_word;
  logic last_lut;
  int   off;

  assign last_word = (cnt_q == LAST_CNT);
  assign last_lut  = (idx_q == LAST_IDX);
  assign off       = int'(cnt_q) * CONFIG_WIDTH;
  assign hs        = s_valid && s_ready;

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_LOAD;
        end
        S_LOAD: begin
          if (hs && last_word) state_d = S_COMMIT;
        end
        S_COMMIT: begin
          state_d = last_lut ? S_IDLE : S_LOAD;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Ready never looks at s_valid, only at state and abort.
  always_comb begin
    s_ready = (state_q == S_LOAD) && !abort;
    busy    = (state_q != S_IDLE);
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    cfg_d   = cfg_q;
    cen_d   = '0;
    done_d  = 1'b0;
    if (abort) begin
      cnt_d = '0;
      idx_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_d   = '0;
            idx_d   = '0;
            frame_d = '0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            frame_d[off +: CONFIG_WIDTH] = s_data;
            if (last_word) begin
              cnt_d = '0;
              // Register the whole frame so the bus is stable with cen.
              cfg_d = frame_d;
              cen_d = NUM_LUTS'(1) << idx_q;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_COMMIT: begin
          if (last_lut) begin
            done_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = '0;
          end
        end
        default: begin
          cnt_d = '0;
          idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      cfg_q   <= '0;
      cen_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      cfg_q   <= cfg_d;
      cen_q   <= cen_d;
      done_q  <= done_d;
    end
  end

  assign config_out = cfg_q;
  assign cen        = cen_q;
  assign lut_idx    = idx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader: directed stimulus with a queue-based scoreboard
// and monitors checking commit and done events.
module tb_lut_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, abort, s_valid, s_ready;
  logic [3:0]  s_data;
  logic [15:0] config_out;
  logic [1:0]  cen;
  logic [0:0]  lut_idx;
  logic        busy, done;

  logic        start1, abort1, s_valid1, s_ready1;
  logic [15:0] s_data1;
  logic [15:0] config_out1;
  logic [0:0]  cen1;
  logic [0:0]  lut_idx1;
  logic        busy1, done1;

  lut_cfg_loader #(
    .NUM_LUTS(2), .INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(4)
  ) dut (
    .cclk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .config_out(config_out), .cen(cen), .lut_idx(lut_idx),
    .busy(busy), .done(done)
  );

  lut_cfg_loader #(
    .NUM_LUTS(1), .INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(16)
  ) dut1 (
    .cclk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .config_out(config_out1), .cen(cen1), .lut_idx(lut_idx1),
    .busy(busy1), .done(done1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int t1    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    logic [7:0]  cen;
    logic [15:0] frame;
    logic [7:0]  idx;
    int          cyc;
    bit          chk_cyc;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit d, input logic [7:0] c,
                              input logic [15:0] f, input logic [7:0] i,
                              input int cy, input bit cc);
    exp_t e;
    e.is_done = d;
    e.cen     = c;
    e.frame   = f;
    e.idx     = i;
    e.cyc     = cy;
    e.chk_cyc = cc;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (cen != 2'b00 || done)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: cen=%b done=%b want none",
                 cen, done);
      end else begin
        e = q.pop_front();
        chk("event_kind", 32'(done), 32'(e.is_done));
        if (e.is_done) begin
          chk("busy_at_done", 32'(busy), 32'(0));
        end else begin
          chk("cen", 32'(cen), 32'(e.cen));
          chk("config_out", 32'(config_out), 32'(e.frame));
          chk("lut_idx", 32'(lut_idx), 32'(e.idx));
          chk("s_ready_commit", 32'(s_ready), 32'(0));
        end
        if (e.chk_cyc) chk("event_cycle", 32'(cyc - t0), 32'(e.cyc));
      end
    end else if (rst_n && busy && !abort) begin
      chk("s_ready_load", 32'(s_ready), 32'(1));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (cen1 != 1'b0 || done1)) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event1: cen=%b done=%b want none",
                 cen1, done1);
      end else begin
        e = q1.pop_front();
        chk("event_kind1", 32'(done1), 32'(e.is_done));
        if (!e.is_done) begin
          chk("cen1", 32'(cen1), 32'(e.cen));
          chk("config_out1", 32'(config_out1), 32'(e.frame));
        end
        if (e.chk_cyc) chk("event_cycle1", 32'(cyc - t1), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] d);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: s_ready=%b want 1", s_ready);
    end
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q1.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain", 32'(q.size() + q1.size()), 32'(0));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    start1 = 1'b0; abort1 = 1'b0; s_valid1 = 1'b0; s_data1 = '0;
    repeat (2) tick();
    chk("rst_s_ready", 32'(s_ready), 32'(0));
    chk("rst_cen", 32'(cen), 32'(0));
    chk("rst_cfg", 32'(config_out), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    // basic load with exact cycle positions
    q.push_back(mk(0, 8'h01, 16'h4321, 8'd0, 5, 1));
    q.push_back(mk(0, 8'h02, 16'h8765, 8'd1, 10, 1));
    q.push_back(mk(1, 8'h00, 16'h0000, 8'd0, 11, 1));
    do_start();
    for (int i = 1; i <= 8; i++) send(4'(i));
    s_valid = 1'b0;
    drain();

    // stalls after every word
    q.push_back(mk(0, 8'h01, 16'h4321, 8'd0, 0, 0));
    q.push_back(mk(0, 8'h02, 16'h8765, 8'd1, 0, 0));
    q.push_back(mk(1, 8'h00, 16'h0000, 8'd0, 0, 0));
    do_start();
    for (int i = 1; i <= 8; i++) begin
      send(4'(i));
      s_valid = 1'b0;
      repeat (3) tick();
    end
    drain();

    // start pulsed during LOAD and COMMIT is ignored
    q.push_back(mk(0, 8'h01, 16'h4321, 8'd0, 5, 1));
    q.push_back(mk(0, 8'h02, 16'h8765, 8'd1, 10, 1));
    q.push_back(mk(1, 8'h00, 16'h0000, 8'd0, 11, 1));
    do_start();
    fork
      begin
        for (int i = 1; i <= 8; i++) send(4'(i));
        s_valid = 1'b0;
      end
      begin
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    join
    drain();

    // abort on third word of LUT 1
    q.push_back(mk(0, 8'h01, 16'h4321, 8'd0, 0, 0));
    do_start();
    for (int i = 1; i <= 6; i++) send(4'(i));
    s_data = 4'h7;
    abort  = 1'b1;
    #1;
    chk("s_ready_abort", 32'(s_ready), 32'(0));
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_idx", 32'(lut_idx), 32'(0));
    chk("abort_cfg", 32'(config_out), 32'(16'h4321));
    repeat (6) tick();
    chk("abort_cfg_hold", 32'(config_out), 32'(16'h4321));
    q.push_back(mk(0, 8'h01, 16'hFFFF, 8'd0, 5, 1));
    q.push_back(mk(0, 8'h02, 16'hFFFF, 8'd1, 10, 1));
    q.push_back(mk(1, 8'h00, 16'h0000, 8'd0, 11, 1));
    do_start();
    for (int i = 0; i < 8; i++) send(4'hF);
    s_valid = 1'b0;
    drain();

    // asynchronous reset during LUT 0 word 2
    do_start();
    send(4'h1);
    send(4'h2);
    s_valid = 1'b1;
    s_data  = 4'h3;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s_ready", 32'(s_ready), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_cen", 32'(cen), 32'(0));
    chk("arst_cfg", 32'(config_out), 32'(0));
    chk("arst_idx", 32'(lut_idx), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_s_ready", 32'(s_ready), 32'(0));
    end
    s_valid = 1'b0;
    tick();

    // single LUT, single word per frame
    q1.push_back(mk(0, 8'h01, 16'hBEEF, 8'd0, 2, 1));
    q1.push_back(mk(1, 8'h00, 16'h0000, 8'd0, 3, 1));
    start1 = 1'b1;
    t1 = cyc;
    tick();
    start1   = 1'b0;
    chk("n1_s_ready", 32'(s_ready1), 32'(1));
    s_valid1 = 1'b1;
    s_data1  = 16'hBEEF;
    tick();
    s_valid1 = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
